// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-way intersection light controller:
// phase codes, default timings and the per-direction lamp bundle.
package semaforo_pkg;

    localparam int ESTADO_W = 3;

    localparam int T_MIN_VERDE_DEF  = 4;
    localparam int T_MAX_VERDE_DEF  = 8;
    localparam int T_AMARELO_DEF    = 2;
    localparam int T_TODOS_VERM_DEF = 1;
    localparam int CNT_W_DEF        = 4;

    typedef enum logic [ESTADO_W-1:0] {
        VERDE_A = 3'd0,
        AMAR_A  = 3'd1,
        VERM_AB = 3'd2,
        VERDE_B = 3'd3,
        AMAR_B  = 3'd4,
        VERM_BA = 3'd5
    } fase_t;

    typedef struct packed {
        logic verd;
        logic amar;
        logic verm;
    } lampada_t;

    localparam lampada_t LAMP_VERDE = '{verd: 1'b1, amar: 1'b0, verm: 1'b0};
    localparam lampada_t LAMP_AMAR  = '{verd: 1'b0, amar: 1'b1, verm: 1'b0};
    localparam lampada_t LAMP_VERM  = '{verd: 1'b0, amar: 1'b0, verm: 1'b1};

endpackage

// File: rtl/semaforo_timer.sv
// Phase duration counter: counts time-base ticks spent in the current phase,
// saturating at all-ones, cleared whenever the phase changes.
module semaforo_timer
    import semaforo_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-way intersection light controller: demand-driven green phases with
// min/max green, fixed yellow and all-red clearance, Moore lamp decode.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int T_MIN_VERDE  = T_MIN_VERDE_DEF,
    parameter int T_MAX_VERDE  = T_MAX_VERDE_DEF,
    parameter int T_AMARELO    = T_AMARELO_DEF,
    parameter int T_TODOS_VERM = T_TODOS_VERM_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                A,
    input  logic                B,
    output logic                verdA,
    output logic                amarA,
    output logic                verA,
    output logic                verdB,
    output logic                amarB,
    output logic                verB,
    output logic [ESTADO_W-1:0] estado
);

    localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(T_MIN_VERDE - 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(T_MAX_VERDE - 1);
    localparam logic [CNT_W-1:0] L_AMAR = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] L_VERM = CNT_W'(T_TODOS_VERM - 1);

    fase_t            r_estado;
    fase_t            w_prox;
    logic             w_clr;
    logic [CNT_W-1:0] w_cnt;
    lampada_t         w_lamp_a;
    lampada_t         w_lamp_b;

    semaforo_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_tick (tick),
        .i_clr  (w_clr),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= VERDE_A;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Green ends only while the other side still demands; a conflicting
    // demand on this side stretches green up to the max limit.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            VERDE_A: if (tick && B && (w_cnt >= L_MIN) && (!A || (w_cnt >= L_MAX))) w_prox = AMAR_A;
            AMAR_A:  if (tick && (w_cnt == L_AMAR)) w_prox = VERM_AB;
            VERM_AB: if (tick && (w_cnt == L_VERM)) w_prox = VERDE_B;
            VERDE_B: if (tick && A && (w_cnt >= L_MIN) && (!B || (w_cnt >= L_MAX))) w_prox = AMAR_B;
            AMAR_B:  if (tick && (w_cnt == L_AMAR)) w_prox = VERM_BA;
            VERM_BA: if (tick && (w_cnt == L_VERM)) w_prox = VERDE_A;
            default: w_prox = VERDE_A;
        endcase
    end

    // Illegal codes also differ from VERDE_A, so recovery restarts the count.
    assign w_clr = (w_prox != r_estado);

    // NOTE: every output gets a default before the case, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        w_lamp_a = LAMP_VERDE;
        w_lamp_b = LAMP_VERM;
        case (r_estado)
            AMAR_A:  w_lamp_a = LAMP_AMAR;
            VERM_AB: w_lamp_a = LAMP_VERM;
            VERDE_B: begin
                w_lamp_a = LAMP_VERM;
                w_lamp_b = LAMP_VERDE;
            end
            AMAR_B: begin
                w_lamp_a = LAMP_VERM;
                w_lamp_b = LAMP_AMAR;
            end
            VERM_BA: w_lamp_a = LAMP_VERM;
            default: ;
        endcase
    end

    assign {verdA, amarA, verA} = w_lamp_a;
    assign {verdB, amarB, verB} = w_lamp_b;
    assign estado               = r_estado;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl: reference model feeds a scoreboard
// queue, plus directed per-scenario phase-sequence checks.
module tb_semaforo_ctrl;

    localparam int TMIN   = 4;
    localparam int TMAX   = 8;
    localparam int TAMAR  = 2;
    localparam int TVERM  = 1;
    localparam int CNTMAX = 15;

    typedef struct packed {
        logic [2:0] estado;
        logic [5:0] lamps;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic       A    = 1'b0;
    logic       B    = 1'b0;
    logic       verdA, amarA, verA, verdB, amarB, verB;
    logic [2:0] estado;

    int n_cmp = 0;
    int n_err = 0;

    int   m_phase = 0;
    int   m_cnt   = 0;
    exp_t sb_q[$];

    // {verdA, amarA, verA, verdB, amarB, verB} per phase code
    logic [5:0] lamp_tab [6] = '{6'b100001, 6'b010001, 6'b001001,
                                 6'b001100, 6'b001010, 6'b001001};

    semaforo_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .A      (A),
        .B      (B),
        .verdA  (verdA),
        .amarA  (amarA),
        .verA   (verA),
        .verdB  (verdB),
        .amarB  (amarB),
        .verB   (verB),
        .estado (estado)
    );

    always #5 clk = ~clk;

    function automatic void model_step(input bit t, input bit a, input bit b);
        int nxt;
        if (!t) return;
        nxt = m_phase;
        case (m_phase)
            0: if (b && m_cnt >= TMIN - 1 && (!a || m_cnt >= TMAX - 1)) nxt = 1;
            1: if (m_cnt == TAMAR - 1) nxt = 2;
            2: if (m_cnt == TVERM - 1) nxt = 3;
            3: if (a && m_cnt >= TMIN - 1 && (!b || m_cnt >= TMAX - 1)) nxt = 4;
            4: if (m_cnt == TAMAR - 1) nxt = 5;
            5: if (m_cnt == TVERM - 1) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_cnt   = 0;
        end else if (m_cnt < CNTMAX) begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    // Drive one clock: inputs set away from the edge, expected result queued,
    // returns on the following falling edge.
    task automatic cycle(input bit t, input bit a, input bit b);
        exp_t e;
        tick = t;
        A    = a;
        B    = b;
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            model_step(t, a, b);
        end
        e.estado = 3'(m_phase);
        e.lamps  = lamp_tab[m_phase];
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard and invariant monitor, sampled 1 time unit after each edge.
    always @(posedge clk) begin
        exp_t e;
        logic [8:0] obs;
        #1;
        obs = {estado, verdA, amarA, verA, verdB, amarB, verB};
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== {e.estado, e.lamps}) begin
                n_err++;
                $display("FAIL scoreboard @%0t: got estado=%0d lamps=%b, want estado=%0d lamps=%b",
                         $time, estado, obs[5:0], e.estado, e.lamps);
            end
        end
        n_cmp++;
        if (((32'(verdA) + 32'(amarA) + 32'(verA)) != 1) ||
            ((32'(verdB) + 32'(amarB) + 32'(verB)) != 1) ||
            ((verdA | amarA) && (verdB | amarB)) || (estado > 3'd5)) begin
            n_err++;
            $display("FAIL invariant @%0t: got estado=%0d lamps=%b, want one lamp per side, no conflict, estado<6",
                     $time, estado, obs[5:0]);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({estado, verdA, amarA, verA, verdB, amarB, verB} !== 9'b000_100001) begin
            n_err++;
            $display("FAIL reset_values: got estado=%0d lamps=%b, want estado=0 lamps=100001",
                     estado, {verdA, amarA, verA, verdB, amarB, verB});
        end
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (estado !== 3'd0 || verdA !== 1'b1 || verB !== 1'b1) begin
                n_err++;
                $display("FAIL idle_rest_green cycle %0d: got estado=%0d verdA=%b verB=%b, want 0 1 1",
                         k, estado, verdA, verB);
            end
        end
    endtask

    task automatic test_b_demand();
        logic [2:0] want;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 1'b1);
            want = (k <= 3) ? 3'd0 : (k <= 5) ? 3'd1 : (k == 6) ? 3'd2 : 3'd3;
            n_cmp++;
            if (estado !== want) begin
                n_err++;
                $display("FAIL b_demand edge %0d: got estado=%0d, want %0d", k, estado, want);
            end
        end
        n_cmp++;
        if (verdB !== 1'b1 || verA !== 1'b1) begin
            n_err++;
            $display("FAIL b_demand_lamps: got verdB=%b verA=%b, want 1 1", verdB, verA);
        end
    endtask

    task automatic test_both_demand();
        logic [2:0] want;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (k <= 7)       want = 3'd0;
            else if (k <= 9)  want = 3'd1;
            else if (k == 10) want = 3'd2;
            else if (k <= 18) want = 3'd3;
            else if (k <= 20) want = 3'd4;
            else if (k == 21) want = 3'd5;
            else              want = 3'd0;
            n_cmp++;
            if (estado !== want) begin
                n_err++;
                $display("FAIL both_demand edge %0d: got estado=%0d, want %0d", k, estado, want);
            end
        end
    endtask

    task automatic test_tick_div3();
        logic [2:0] want;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle((k % 3) == 0, 1'b0, 1'b1);
            want = (k < 12) ? 3'd0 : 3'd1;
            n_cmp++;
            if (estado !== want) begin
                n_err++;
                $display("FAIL div3_green edge %0d: got estado=%0d, want %0d", k, estado, want);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (estado !== 3'd1) begin
                n_err++;
                $display("FAIL tick_freeze cycle %0d: got estado=%0d, want 1", k, estado);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            cycle((k % 3) == 0, 1'b0, 1'b1);
            want = (k < 6) ? 3'd1 : (k < 9) ? 3'd2 : 3'd3;
            n_cmp++;
            if (estado !== want) begin
                n_err++;
                $display("FAIL div3_amber edge %0d: got estado=%0d, want %0d", k, estado, want);
            end
        end
    endtask

    task automatic test_demand_withdrawn();
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (estado !== 3'd0) begin
                n_err++;
                $display("FAIL withdrawn_hold cycle %0d: got estado=%0d, want 0", k, estado);
            end
        end
    endtask

    task automatic test_reset_mid_amar_b();
        int k;
        do_reset();
        k = 0;
        while (estado !== 3'd3 && k < 60) begin
            cycle(1'b1, 1'b0, 1'b1);
            k++;
        end
        k = 0;
        while (estado !== 3'd4 && k < 60) begin
            cycle(1'b1, 1'b1, 1'b0);
            k++;
        end
        n_cmp++;
        if (estado !== 3'd4) begin
            n_err++;
            $display("FAIL reach_amar_b: got estado=%0d, want 4 within 60 cycles", estado);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({estado, verdA, amarA, verA, verdB, amarB, verB} !== 9'b000_100001) begin
            n_err++;
            $display("FAIL async_reset: got estado=%0d lamps=%b, want estado=0 lamps=100001 before clk",
                     estado, {verdA, amarA, verA, verdB, amarB, verB});
        end
        m_phase = 0;
        m_cnt   = 0;
        cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cycle(1'b1, 1'b1, 1'b0);
        end
        n_cmp++;
        if (estado !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_hold: got estado=%0d, want 0", estado);
        end
    endtask

    initial begin
        test_reset();
        test_b_demand();
        test_both_demand();
        test_tick_div3();
        test_demand_withdrawn();
        test_reset_mid_amar_b();
        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
